// File: rtl/d_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default sizes,
// port indices and the address legality check.
package d_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // Byte address must be word aligned and fall inside the word array.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= 32'(depth * 4));
    endfunction

endpackage

// File: rtl/d_mem_sync_ram.sv
// Single-port word RAM: synchronous write, registered read, array not reset.
module d_mem_sync_ram #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/d_mem_arbiter.sv
// Two-port round-robin controller for the data memory: one access in flight,
// one response per accepted request, bad addresses answered with err.
module d_mem_arbiter
    import d_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err
);

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   resp_port_q, resp_port_d;
    logic   resp_err_q, resp_err_d;
    logic   resp_ld_q, resp_ld_d;

    logic              gnt0, gnt1, accept;
    logic              sel_we, sel_bad;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] ram_rdata, resp_rdata;

    assign sel_we    = gnt1 ? p1_we    : p0_we;
    assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
    assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign sel_bad   = addr_bad(sel_addr, DEPTH);
    assign accept    = gnt0 | gnt1;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        resp_port_d = resp_port_q;
        resp_err_d  = resp_err_q;
        resp_ld_d   = resp_ld_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the port that lost the previous contest wins.
                if (p0_req && p1_req) begin
                    gnt0 = (last_gnt_q == PORT_LDR);
                    gnt1 = (last_gnt_q == PORT_CPU);
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
                if (gnt0 || gnt1) begin
                    state_d     = ST_RESP;
                    last_gnt_d  = gnt1 ? PORT_LDR : PORT_CPU;
                    resp_port_d = gnt1 ? PORT_LDR : PORT_CPU;
                    resp_err_d  = sel_bad;
                    resp_ld_d   = !sel_we && !sel_bad;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= PORT_LDR;
            resp_port_q <= PORT_CPU;
            resp_err_q  <= 1'b0;
            resp_ld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            resp_port_q <= resp_port_d;
            resp_err_q  <= resp_err_d;
            resp_ld_q   <= resp_ld_d;
        end
    end

    // Rejected addresses never touch the array, neither read nor write.
    d_mem_sync_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept && sel_we && !sel_bad),
        .re_i    (accept && !sel_we && !sel_bad),
        .addr_i  (sel_addr[ADDR_W+1:2]),
        .wdata_i (sel_wdata),
        .rdata_o (ram_rdata)
    );

    assign resp_rdata = resp_ld_q ? ram_rdata : '0;

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = (state_q == ST_RESP) && (resp_port_q == PORT_CPU);
    assign p1_rvalid = (state_q == ST_RESP) && (resp_port_q == PORT_LDR);
    assign p0_rdata  = p0_rvalid ? resp_rdata : '0;
    assign p1_rdata  = p1_rvalid ? resp_rdata : '0;
    assign p0_err    = p0_rvalid && resp_err_q;
    assign p1_err    = p1_rvalid && resp_err_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: transaction-level model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_d_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    d_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_pend = 0;      // a response is owed in the current cycle
    int          m_port = 0;
    int          m_last = 1;
    bit          m_err = 0;
    bit          m_rd_known = 0;
    logic [31:0] m_rd = '0;

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend = 0;
                m_last = 1;
            end else begin
                int g;
                g = -1;
                if (!m_pend) begin
                    if (req[0] && req[1]) g = 1 - m_last;
                    else if (req[0])      g = 0;
                    else if (req[1])      g = 1;
                end
                m_pend = (g >= 0);
                if (g >= 0) begin
                    int idx;
                    m_port = g;
                    m_last = g;
                    m_err = (addr[g] % 4 != 0) || (addr[g] >= 256);
                    m_rd = '0;
                    m_rd_known = 1;
                    idx = int'(addr[g] / 4) % 64;
                    if (!m_err) begin
                        if (we[g]) begin
                            m_mem[idx] = wdata[g];
                            m_known[idx] = 1;
                        end else begin
                            m_rd = m_mem[idx];
                            m_rd_known = m_known[idx];
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic [1:0] eg;
            @(negedge clk);
            eg = '0;
            if (!m_pend) begin
                if (req[0] && req[1]) eg[1 - m_last] = 1'b1;
                else eg = req;
            end
            chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, eg});
            chk("rvalid_err",
                {28'd0, p1_rvalid, p0_rvalid, p1_err, p0_err},
                {28'd0, m_pend && m_port == 1, m_pend && m_port == 0,
                 m_pend && m_port == 1 && m_err, m_pend && m_port == 0 && m_err});
            if (!(m_pend && m_port == 0) || m_rd_known) chk("p0_rdata", p0_rdata, (m_pend && m_port == 0) ? m_rd : 32'd0);
            if (!(m_pend && m_port == 1) || m_rd_known) chk("p1_rdata", p1_rdata, (m_pend && m_port == 1) ? m_rd : 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic rv, output logic er, output logic [31:0] rd);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (p == 0) ? p0_gnt : p1_gnt;
        end
        chk("gnt_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
        @(negedge clk);
        rv = (p == 0) ? p0_rvalid : p1_rvalid;
        er = (p == 0) ? p0_err : p1_err;
        rd = (p == 0) ? p0_rdata : p1_rdata;
    endtask

    logic        rv, er;
    logic [31:0] rd;
    logic [1:0]  gs;
    logic [7:0]  exp_g [8];
    logic [7:0]  exp_v [8];

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        #12 chk("reset_outputs", {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err} | p0_rdata | p1_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, rv, er, rd);
        chk("st10_rv_err", {30'd0, rv, er}, 32'b10);
        access(0, 1'b0, 32'h10, 32'h0, rv, er, rd);
        chk("ld10_rdata", rd, 32'hDEADBEEF);

        access(1, 1'b1, 32'h0, 32'hA5A50000, rv, er, rd);
        access(1, 1'b0, 32'h0102, 32'h0, rv, er, rd);
        chk("misalign", {rv, er} | rd, 32'b11);
        access(1, 1'b0, 32'h100, 32'h0, rv, er, rd);
        chk("oor_load", {rv, er} | rd, 32'b11);
        access(1, 1'b1, 32'h100, 32'hBAD0BAD0, rv, er, rd);
        chk("oor_store", {30'd0, rv, er}, 32'b11);
        access(1, 1'b0, 32'h0, 32'h0, rv, er, rd);
        chk("word0_intact", rd, 32'hA5A50000);

        // Continuous tie: grants alternate, each response two cycles apart.
        exp_g = '{8'h1, 8'h0, 8'h2, 8'h0, 8'h1, 8'h0, 8'h2, 8'h0};
        exp_v = '{8'h0, 8'h1, 8'h0, 8'h2, 8'h0, 8'h1, 8'h0, 8'h2};
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("tie_gnt%0d", i), {30'd0, p1_gnt, p0_gnt}, {24'd0, exp_g[i]});
            chk($sformatf("tie_rv%0d", i), {30'd0, p1_rvalid, p0_rvalid}, {24'd0, exp_v[i]});
        end
        @(posedge clk); #1; req = 2'b00;

        access(1, 1'b1, 32'h3C, 32'h12345678, rv, er, rd);
        access(0, 1'b0, 32'h3C, 32'h0, rv, er, rd);
        chk("cross_port", rd, 32'h12345678);

        // Reset in the middle of a load response.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        @(negedge clk);
        chk("pre_rst_gnt", {31'd0, p0_gnt}, 32'd1);
        @(posedge clk); #1; req[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("rst_outputs", {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err} | p0_rdata | p1_rdata, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h3C;
        @(negedge clk);
        chk("post_rst_tie", {30'd0, p1_gnt, p0_gnt}, 32'b01);
        @(posedge clk); #1; req = 2'b00;
        @(negedge clk);
        chk("post_rst_data", p0_rdata, 32'hDEADBEEF);

        // Randomized traffic with holds, drops and bad addresses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            gs = {p1_gnt, p0_gnt};
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (req[p] && gs[p]) req[p] = 1'b0;
                else if (req[p] && $urandom_range(0, 19) == 0) req[p] = 1'b0;
                if (!req[p] && $urandom_range(0, 2) != 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    req[p] = 1'b1;
                    we[p] = $urandom_range(0, 1) == 1;
                    wdata[p] = $urandom;
                    if (r < 8)       addr[p] = 32'($urandom_range(0, 63)) * 4;
                    else if (r == 8) addr[p] = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                    else             addr[p] = 32'd256 + 32'($urandom_range(0, 4096));
                end
            end
        end
        @(posedge clk); #1; req = 2'b00;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
